// File: rtl/sid_bus_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | sid_bus_arbiter_pkg: shared SID bus types plus the host arbiter types.   |
// | Host read path is enabled by SID_ARB_HOST_READ_EN. Rev 1.0               |
// +--------------------------------------------------------------------------+
`default_nettype none

package sid_bus_arbiter_pkg;

  typedef logic [7:0] reg8_t;
  typedef logic [1:0] phase_t;

  localparam int PHI1 = 0;
  localparam int PHI2 = 1;

  typedef struct packed {
    logic       res;
    logic       we;
    logic       oe;
    logic [4:0] addr;
    reg8_t      data;
  } bus_i_t;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    reg8_t      data;
  } host_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_CAPTURE = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/sid_arb_fifo.sv
// +--------------------------------------------------------------------------+
// | sid_arb_fifo: synchronous FIFO of host_req_t with flush. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module sid_arb_fifo
  import sid_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      res,
  input  logic      flush_i,
  input  logic      push_i,
  input  host_req_t data_i,
  input  logic      pop_i,
  output host_req_t data_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  host_req_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/sid_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | sid_bus_arbiter: shares the sid_core bus between the C64 and a host      |
// | port; host accesses use free PHI2 slots. Macro: SID_ARB_HOST_READ_EN.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sid_bus_arbiter
  import sid_bus_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic       clk,
  input  logic       res,
  input  phase_t     phase,
  input  bus_i_t     c64_bus_i,
  input  logic       c64_cs,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [4:0] host_addr,
  input  reg8_t      host_data,
  output logic       host_ack,
  output logic       host_rvalid,
  output reg8_t      host_rdata,
  output logic       host_stall,
  output bus_i_t     core_bus_o,
  output logic       core_cs,
  input  reg8_t      core_data_i
);

  localparam logic [7:0] WAIT_LIMIT = (MAX_WAIT > 255) ? 8'hFF : 8'(MAX_WAIT);

  arb_state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       ack_q;
  logic       stall_q;
  logic       w_c64_busy;
  logic       w_slot;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_issue;
  logic       w_empty;
  logic       w_full;
  host_req_t  w_head;
  host_req_t  w_new;
  logic       w_unused_phi1;

  assign w_unused_phi1 = phase[PHI1];
  assign w_c64_busy    = c64_cs && (c64_bus_i.we || c64_bus_i.oe);
  assign w_slot        = phase[PHI2] && !w_c64_busy && !c64_bus_i.res;
  // ack_q blocks a second accept while the host is still seeing its ack.
  assign w_accept      = host_req && !w_full && !ack_q && !c64_bus_i.res;
`ifdef SID_ARB_HOST_READ_EN
  assign w_push        = w_accept;
`else
  assign w_push        = w_accept && host_we;
`endif
  assign w_new         = '{we: host_we, addr: host_addr, data: host_data};

  sid_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .res     (res),
    .flush_i (c64_bus_i.res),
    .push_i  (w_push),
    .data_i  (w_new),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    w_pop   = 1'b0;
    w_issue = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!w_empty) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        wait_d = wait_q;
        if (w_slot) begin
          w_issue = 1'b1;
          w_pop   = 1'b1;
          wait_d  = '0;
`ifdef SID_ARB_HOST_READ_EN
          state_d = w_head.we ? ARB_IDLE : ARB_CAPTURE;
`else
          state_d = ARB_IDLE;
`endif
        end else if (phase[PHI2] && (wait_q != 8'hFF)) begin
          wait_d = wait_q + 8'd1;
        end
      end
`ifdef SID_ARB_HOST_READ_EN
      ARB_CAPTURE: begin
        state_d = ARB_IDLE;
      end
`endif
      default: state_d = ARB_IDLE;
    endcase
    // A C64 reset flushes the queue but lets an in-flight capture finish.
    if (c64_bus_i.res && (state_q != ARB_CAPTURE)) state_d = ARB_IDLE;
  end

  always_comb begin
    core_bus_o = c64_bus_i;
    core_cs    = c64_cs;
    if (w_issue) begin
      core_bus_o.addr = w_head.addr;
      core_bus_o.data = w_head.data;
      core_bus_o.we   = w_head.we;
      core_bus_o.oe   = !w_head.we;
      core_cs         = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ack_q   <= w_accept;
      if ((state_q == ARB_ISSUE) && (wait_q >= WAIT_LIMIT)) stall_q <= 1'b1;
    end
  end

  assign host_ack   = ack_q;
  assign host_stall = stall_q;

`ifdef SID_ARB_HOST_READ_EN
  logic  rvalid_q;
  reg8_t rdata_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= (state_q == ARB_CAPTURE);
      if (state_q == ARB_CAPTURE) rdata_q <= core_data_i;
    end
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
`else
  logic w_unused_rdata;

  assign w_unused_rdata = ^core_data_i;
  assign host_rvalid    = 1'b0;
  assign host_rdata     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sid_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_sid_bus_arbiter: directed vector table plus multi-cycle sequences.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sid_bus_arbiter;
  import sid_bus_arbiter_pkg::*;

`ifdef SID_ARB_HOST_READ_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif
  localparam phase_t PH2 = 2'b10;
  localparam phase_t PH1 = 2'b01;

  logic       clk = 1'b0;
  logic       res;
  phase_t     phase;
  bus_i_t     c64_bus_i;
  logic       c64_cs;
  logic       host_req;
  logic       host_we;
  logic [4:0] host_addr;
  reg8_t      host_data;
  logic       host_ack;
  logic       host_rvalid;
  reg8_t      host_rdata;
  logic       host_stall;
  bus_i_t     core_bus_o;
  logic       core_cs;
  reg8_t      core_data_i;

  int total = 0;
  int bad   = 0;
  reg8_t regs [32];

  always #5 clk = ~clk;

  sid_bus_arbiter #(
    .FIFO_DEPTH (2),
    .MAX_WAIT   (255)
  ) dut (
    .clk         (clk),
    .res         (res),
    .phase       (phase),
    .c64_bus_i   (c64_bus_i),
    .c64_cs      (c64_cs),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .host_ack    (host_ack),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_stall  (host_stall),
    .core_bus_o  (core_bus_o),
    .core_cs     (core_cs),
    .core_data_i (core_data_i)
  );

  // Minimal sid_core register file: writes land on a PHI2 edge.
  always @(posedge clk) begin
    if (phase[PHI2] && core_cs && core_bus_o.we) regs[core_bus_o.addr] <= core_bus_o.data;
  end

  typedef struct {
    logic       phi2;
    bus_i_t     c64;
    logic       c64_cs;
    logic       req;
    logic       we;
    logic [4:0] addr;
    reg8_t      data;
    reg8_t      cdat;
    logic       e_cs;
    bus_i_t     e_bus;
    logic       e_ack;
    logic       e_rv;
    reg8_t      e_rd;
  } vec_t;

  function automatic bus_i_t mkbus(input logic w, input logic o, input logic [4:0] a, input reg8_t d);
    mkbus = '{res: 1'b0, we: w, oe: o, addr: a, data: d};
  endfunction

  function automatic vec_t row(input logic p, input bus_i_t b, input logic cs, input logic rq,
                               input logic w, input logic [4:0] a, input reg8_t d, input reg8_t cd,
                               input logic ecs, input bus_i_t eb, input logic ea, input logic erv,
                               input reg8_t erd);
    row.phi2 = p;  row.c64 = b;    row.c64_cs = cs; row.req = rq;  row.we = w;
    row.addr = a;  row.data = d;   row.cdat = cd;   row.e_cs = ecs; row.e_bus = eb;
    row.e_ack = ea; row.e_rv = erv; row.e_rd = erd;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input phase_t p, input bus_i_t b, input logic cs);
    phase     = p;
    c64_bus_i = b;
    c64_cs    = cs;
  endtask

  // Host presents a request and holds it until host_ack, then drops it one cycle.
  task automatic host_send(input string name, input logic w, input logic [4:0] a, input reg8_t d,
                           input int budget);
    bit got = 1'b0;
    @(negedge clk);
    host_req = 1'b1; host_we = w; host_addr = a; host_data = d;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      if (host_ack) got = 1'b1;
    end
    chk(name, 32'(got), 32'd1);
    @(negedge clk);
    host_req = 1'b0;
  endtask

  task automatic wait_issue(input string name, input bus_i_t exp, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      drive(PH2, mkbus(1'b0, 1'b0, 5'h00, 8'h00), 1'b0);
      #1;
      if (core_cs) begin
        seen = 1'b1;
        chk(name, 32'(core_bus_o), 32'(exp));
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s: no host issue within %0d cycles", name, budget);
    end
    @(negedge clk);
    phase = 2'b00;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit leak = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      drive(PH2, mkbus(1'b0, 1'b0, 5'h00, 8'h00), 1'b0);
      #1;
      if (core_cs) leak = 1'b1;
    end
    chk(name, 32'(leak), 32'd0);
    @(negedge clk);
    phase = 2'b00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tv [16];
    bus_i_t idle_b;
    bus_i_t c64w;
    bit     early;
    bit     leak;
    logic   mid_stall;

    idle_b = mkbus(1'b0, 1'b0, 5'h00, 8'h00);
    c64w   = mkbus(1'b1, 1'b0, 5'h05, 8'h12);

    // Writes 0x18<=0x0F, C64-vs-host on one PHI2, then a read of osc3.
    tv[0]  = row(0, idle_b, 0, 1, 1, 5'h18, 8'h0F, 8'h00, 0, idle_b, 0, 0, 8'h00);
    tv[1]  = row(0, idle_b, 0, 1, 1, 5'h18, 8'h0F, 8'h00, 0, idle_b, 1, 0, 8'h00);
    tv[2]  = row(1, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'h00, 1, mkbus(1, 0, 5'h18, 8'h0F), 0, 0, 8'h00);
    tv[3]  = row(0, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, idle_b, 0, 0, 8'h00);
    tv[4]  = row(0, idle_b, 0, 1, 1, 5'h06, 8'h34, 8'h00, 0, idle_b, 0, 0, 8'h00);
    tv[5]  = row(0, idle_b, 0, 1, 1, 5'h06, 8'h34, 8'h00, 0, idle_b, 1, 0, 8'h00);
    tv[6]  = row(1, c64w,   1, 0, 0, 5'h00, 8'h00, 8'h00, 1, c64w,   0, 0, 8'h00);
    tv[7]  = row(0, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, idle_b, 0, 0, 8'h00);
    tv[8]  = row(1, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'h00, 1, mkbus(1, 0, 5'h06, 8'h34), 0, 0, 8'h00);
    tv[9]  = row(0, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, idle_b, 0, 0, 8'h00);
    tv[10] = row(0, idle_b, 0, 1, 0, 5'h1B, 8'h00, 8'hA5, 0, idle_b, 0, 0, 8'h00);
    tv[11] = row(0, idle_b, 0, 1, 0, 5'h1B, 8'h00, 8'hA5, 0, idle_b, 1, 0, 8'h00);
    tv[12] = row(1, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'hA5, RD,
                 RD ? mkbus(0, 1, 5'h1B, 8'h00) : idle_b, 0, 0, 8'h00);
    tv[13] = row(0, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'hA5, 0, idle_b, 0, 0, 8'h00);
    tv[14] = row(0, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'hA5, 0, idle_b, 0, RD, RD ? 8'hA5 : 8'h00);
    tv[15] = row(0, idle_b, 0, 0, 0, 5'h00, 8'h00, 8'hA5, 0, idle_b, 0, 0, RD ? 8'hA5 : 8'h00);

    res = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_data = '0; core_data_i = '0;
    drive(2'b00, mkbus(1'b1, 1'b0, 5'h0C, 8'h5A), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("reset core_bus", 32'(core_bus_o), 32'(mkbus(1'b1, 1'b0, 5'h0C, 8'h5A)));
    chk("reset core_cs", 32'(core_cs), 32'd1);
    chk("reset ack", 32'(host_ack), 32'd0);
    chk("reset rvalid", 32'(host_rvalid), 32'd0);
    chk("reset rdata", 32'(host_rdata), 32'd0);
    chk("reset stall", 32'(host_stall), 32'd0);
    @(negedge clk);
    res = 1'b0;
    drive(2'b00, idle_b, 1'b0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tv[i].phi2 ? PH2 : PH1, tv[i].c64, tv[i].c64_cs);
      host_req = tv[i].req; host_we = tv[i].we; host_addr = tv[i].addr; host_data = tv[i].data;
      core_data_i = tv[i].cdat;
      #1;
      chk($sformatf("v%0d core_cs", i), 32'(core_cs), 32'(tv[i].e_cs));
      chk($sformatf("v%0d core_bus", i), 32'(core_bus_o), 32'(tv[i].e_bus));
      chk($sformatf("v%0d ack", i), 32'(host_ack), 32'(tv[i].e_ack));
      chk($sformatf("v%0d rvalid", i), 32'(host_rvalid), 32'(tv[i].e_rv));
      chk($sformatf("v%0d rdata", i), 32'(host_rdata), 32'(tv[i].e_rd));
      chk($sformatf("v%0d stall", i), 32'(host_stall), 32'd0);
    end
    chk("reg18", 32'(regs[5'h18]), 32'h0F);
    chk("reg05", 32'(regs[5'h05]), 32'h12);
    chk("reg06", 32'(regs[5'h06]), 32'h34);

    // Three requests into a two-deep queue with no slots available.
    @(negedge clk);
    drive(2'b00, idle_b, 1'b0);
    host_send("t4 ack A", 1'b1, 5'h01, 8'h11, 4);
    host_send("t4 ack B", 1'b1, 5'h02, 8'h22, 4);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'h03; host_data = 8'h33;
    early = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (host_ack) early = 1'b1;
    end
    chk("t4 C held while full", 32'(early), 32'd0);
    @(negedge clk);
    phase = PH2;
    #1;
    chk("t4 A issue", 32'(core_bus_o), 32'(mkbus(1, 0, 5'h01, 8'h11)));
    @(negedge clk);
    phase = 2'b00;
    @(posedge clk); #1;
    chk("t4 C ack after pop", 32'(host_ack), 32'd1);
    @(negedge clk);
    host_req = 1'b0;
    wait_issue("t4 B issue", mkbus(1, 0, 5'h02, 8'h22), 6);
    wait_issue("t4 C issue", mkbus(1, 0, 5'h03, 8'h33), 6);

    // C64 takes every PHI2 for 256 periods while a host write waits.
    host_send("t5 ack", 1'b1, 5'h07, 8'h55, 4);
    leak = 1'b0;
    mid_stall = 1'b0;
    for (int p = 0; p < 256; p++) begin
      @(negedge clk);
      drive(PH2, mkbus(1'b1, 1'b0, 5'h0A, p[7:0]), 1'b1);
      #1;
      if (!core_cs || (core_bus_o !== mkbus(1'b1, 1'b0, 5'h0A, p[7:0]))) leak = 1'b1;
      @(negedge clk);
      drive(PH1, idle_b, 1'b0);
      if (p == 200) mid_stall = host_stall;
    end
    chk("t5 c64 priority", 32'(leak), 32'd0);
    chk("t5 stall early", 32'(mid_stall), 32'd0);
    chk("t5 stall set", 32'(host_stall), 32'd1);
    wait_issue("t5 host issue", mkbus(1, 0, 5'h07, 8'h55), 4);
    chk("t5 reg07", 32'(regs[5'h07]), 32'h55);
    chk("t5 stall sticky", 32'(host_stall), 32'd1);

    // Async reset while a request sits in ISSUE.
    host_send("t6 ack", 1'b1, 5'h08, 8'h66, 4);
    @(negedge clk);
    drive(PH2, mkbus(1'b0, 1'b0, 5'h1F, 8'hC3), 1'b0);
    #2 res = 1'b1;
    #1;
    chk("t6 core_cs", 32'(core_cs), 32'd0);
    chk("t6 core_bus", 32'(core_bus_o), 32'(mkbus(1'b0, 1'b0, 5'h1F, 8'hC3)));
    chk("t6 ack", 32'(host_ack), 32'd0);
    chk("t6 rvalid", 32'(host_rvalid), 32'd0);
    chk("t6 rdata", 32'(host_rdata), 32'd0);
    chk("t6 stall", 32'(host_stall), 32'd0);
    repeat (2) @(negedge clk);
    res = 1'b0;
    expect_quiet("t6 entry dropped", 6);

    // C64 bus reset flushes a queued host write.
    host_send("t7 ack", 1'b1, 5'h09, 8'h77, 4);
    @(negedge clk);
    drive(PH2, '{res: 1'b1, we: 1'b0, oe: 1'b0, addr: 5'h00, data: 8'h00}, 1'b0);
    #1;
    chk("t7 no issue in reset", 32'(core_cs), 32'd0);
    @(negedge clk);
    drive(2'b00, idle_b, 1'b0);
    expect_quiet("t7 entry flushed", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
